widexor_arbiter: RTL and testbench

Multi-beat wide-XOR reduction engine shared between NREQ requesters. Each requester streams one or more WIDTH-bit operands over a valid/ready/last handshake; the block folds them into one accumulator with bitwise XOR and returns the result over a single result channel. It sits in front of the gate-level wide-XOR datapath and serialises access to it with round-robin arbitration, so N-input XOR gates need not be replicated per client.

---
 rtl/widexor_pkg.sv | 36 +++
 rtl/widexor_arbiter_rr_arbiter.sv | 41 ++++
 rtl/widexor_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_widexor_arbiter.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/widexor_pkg.sv
// -----------------------------------------------------------------------------
// widexor_pkg
// Shared types for the wide-XOR reduction arbiter:
//   - state_e    : controller states (IDLE, ACCUM, RESULT)
//   - clog2_min1 : ceil(log2(n)) but never less than 1, for index widths
//   - result_t   : registered result bundle (data, id, count, overflow)
// The RES_* localparams size result_t and are the default values of the
// top-level parameters, so the bundle and the ports line up.
// -----------------------------------------------------------------------------
package widexor_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    RESULT = 2'd2
  } state_e;

  // A single requester still needs a 1-bit id field.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int RES_WIDTH     = 128;
  localparam int RES_NREQ      = 4;
  localparam int RES_MAX_BEATS = 16;
  localparam int RES_ID_W      = clog2_min1(RES_NREQ);
  localparam int RES_CNT_W     = $clog2(RES_MAX_BEATS + 1);

  typedef struct packed {
    logic [RES_WIDTH-1:0] data;
    logic [RES_ID_W-1:0]  id;
    logic [RES_CNT_W-1:0] count;
    logic                 overflow;
  } result_t;

endpackage

// File: rtl/widexor_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin picker: returns the first set request bit
// at or after i_ptr, wrapping around NREQ.
// Ports:
//   i_req        NREQ   request vector
//   i_ptr        ID_W   search start position (always < NREQ)
//   o_grant_oh   NREQ   one-hot winner (all zero when no request)
//   o_grant_idx  ID_W   encoded winner (0 when no request)
// -----------------------------------------------------------------------------
module rr_arbiter
  import widexor_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int ID_W = clog2_min1(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [ID_W-1:0] i_ptr,
  output logic [NREQ-1:0] o_grant_oh,
  output logic [ID_W-1:0] o_grant_idx
);

  always_comb begin
    logic            w_found;
    logic [ID_W-1:0] w_idx;
    o_grant_oh  = '0;
    o_grant_idx = '0;
    w_found     = 1'b0;
    w_idx       = '0;
    // Walk the requesters in priority order starting at i_ptr.
    for (int k = 0; k < NREQ; k++) begin
      w_idx = ID_W'((int'(i_ptr) + k) % NREQ);
      if (!w_found && i_req[w_idx]) begin
        w_found           = 1'b1;
        o_grant_oh[w_idx] = 1'b1;
        o_grant_idx       = w_idx;
      end
    end
  end

endmodule

// File: rtl/widexor_arbiter.sv
// -----------------------------------------------------------------------------
// widexor_arbiter
// Multi-beat wide-XOR reduction engine shared by NREQ requesters. A granted
// requester streams WIDTH-bit operands (valid/ready/last); they are folded
// into one accumulator with XOR and returned on a single result channel.
// Access is serialised with round-robin arbitration.
//
// Optional feature macro: WIDEXOR_ARB_PARITY_EN
//   defined     : res_parity = ^result, registered with res_data
//   not defined : res_parity tied to 0, no reduction logic
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   req_valid     NREQ        per-requester operand valid
//   req_last      NREQ        per-requester final-operand marker
//   req_data      NREQ*WIDTH  operands, requester i at [i*WIDTH +: WIDTH]
//   req_ready     NREQ        per-requester accept (at most one bit set)
//   res_valid     1           result available
//   res_ready     1           result consumer accept
//   res_data      WIDTH       XOR of all accepted operands
//   res_id        ID_W        requester owning the result
//   res_count     CNT_W       operands folded in
//   res_overflow  1           transaction cut at MAX_BEATS without last
//   res_parity    1           reduction XOR of res_data (feature macro)
// -----------------------------------------------------------------------------
module widexor_arbiter
  import widexor_pkg::*;
#(
  parameter  int WIDTH     = RES_WIDTH,
  parameter  int NREQ      = RES_NREQ,
  parameter  int MAX_BEATS = RES_MAX_BEATS,
  localparam int ID_W      = clog2_min1(NREQ),
  localparam int CNT_W     = $clog2(MAX_BEATS + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ-1:0]       req_last,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [WIDTH-1:0]      res_data,
  output logic [ID_W-1:0]       res_id,
  output logic [CNT_W-1:0]      res_count,
  output logic                  res_overflow,
  output logic                  res_parity
);

  state_e           r_state;
  state_e           w_state_next;
  logic [ID_W-1:0]  r_rr_ptr;
  logic [ID_W-1:0]  r_grant;
  logic [NREQ-1:0]  r_grant_oh;
  logic [WIDTH-1:0] r_acc;
  logic [CNT_W-1:0] r_count;
  result_t          r_res;

  logic [ID_W-1:0]  w_arb_idx;
  logic [NREQ-1:0]  w_arb_oh;
  logic [ID_W-1:0]  w_rr_ptr_next;
  logic [WIDTH-1:0] w_req_word [NREQ];
  logic [WIDTH-1:0] w_beat;
  logic             w_beat_valid;
  logic             w_beat_last;
  logic             w_hs;
  logic             w_cap;
  logic             w_exit;
  logic             w_take_last;
  logic             w_overflow;
  logic [WIDTH-1:0] w_acc_next;
  logic [CNT_W-1:0] w_count_inc;

  // Split the flat operand bus into one word per requester.
  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_word
      assign w_req_word[gi] = req_data[gi*WIDTH +: WIDTH];
    end
  endgenerate

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_rr_arbiter (
    .i_req       (req_valid),
    .i_ptr       (r_rr_ptr),
    .o_grant_oh  (w_arb_oh),
    .o_grant_idx (w_arb_idx)
  );

  assign w_beat       = w_req_word[r_grant];
  assign w_beat_valid = req_valid[r_grant];
  assign w_beat_last  = req_last[r_grant];
  assign w_hs         = (r_state == ACCUM) && w_beat_valid;
  assign w_acc_next   = r_acc ^ w_beat;
  assign w_count_inc  = r_count + CNT_W'(1);
  // Hitting the beat limit ends the transaction even without last; that
  // case alone is flagged as an overflow.
  assign w_cap        = (w_count_inc == CNT_W'(MAX_BEATS));
  assign w_exit       = w_beat_last || w_cap;
  assign w_overflow   = w_cap && !w_beat_last;
  assign w_take_last  = w_hs && w_exit;

  // Next round-robin start is the requester after the one just served.
  assign w_rr_ptr_next = (r_grant == ID_W'(NREQ - 1)) ? '0 : r_grant + ID_W'(1);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and handshake outputs
  always_comb begin
    w_state_next = r_state;
    req_ready    = '0;
    res_valid    = 1'b0;
    case (r_state)
      IDLE: begin
        if (|req_valid) begin
          w_state_next = ACCUM;
        end
      end
      ACCUM: begin
        req_ready = r_grant_oh;
        if (w_take_last) begin
          w_state_next = RESULT;
        end
      end
      RESULT: begin
        res_valid = 1'b1;
        if (res_ready) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Grant, accumulator and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr   <= '0;
      r_grant    <= '0;
      r_grant_oh <= '0;
      r_acc      <= '0;
      r_count    <= '0;
      r_res      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_acc   <= '0;
          r_count <= '0;
          if (|req_valid) begin
            r_grant    <= w_arb_idx;
            r_grant_oh <= w_arb_oh;
          end
        end
        ACCUM: begin
          if (w_hs) begin
            r_acc   <= w_acc_next;
            r_count <= w_count_inc;
          end
          // Snapshot the result so it stays stable while RESULT is held.
          if (w_take_last) begin
            r_res.data     <= w_acc_next;
            r_res.id       <= r_grant;
            r_res.count    <= w_count_inc;
            r_res.overflow <= w_overflow;
          end
        end
        RESULT: begin
          if (res_ready) begin
            r_rr_ptr <= w_rr_ptr_next;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign res_data     = r_res.data;
  assign res_id       = r_res.id;
  assign res_count    = r_res.count;
  assign res_overflow = r_res.overflow;

`ifdef WIDEXOR_ARB_PARITY_EN
  logic r_parity;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_parity <= 1'b0;
    end else if (w_take_last) begin
      r_parity <= ^w_acc_next;
    end
  end

  assign res_parity = r_parity;
`else
  assign res_parity = 1'b0;
`endif

endmodule

// File: tb/tb_widexor_arbiter.sv
// -----------------------------------------------------------------------------
// tb_widexor_arbiter
// Directed bench for widexor_arbiter (WIDTH=128, NREQ=4, MAX_BEATS=16).
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_widexor_arbiter;

  localparam int W  = 128;
  localparam int N  = 4;
  localparam int MB = 16;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_last;
  logic [W-1:0]   words [N];
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           res_valid;
  logic           res_ready;
  logic [W-1:0]   res_data;
  logic [1:0]     res_id;
  logic [4:0]     res_count;
  logic           res_overflow;
  logic           res_parity;

  int total = 0;
  int bad   = 0;

  assign req_data = {words[3], words[2], words[1], words[0]};

  always #5 clk = ~clk;

  widexor_arbiter #(
    .WIDTH     (W),
    .NREQ      (N),
    .MAX_BEATS (MB)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_last     (req_last),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_data     (res_data),
    .res_id       (res_id),
    .res_count    (res_count),
    .res_overflow (res_overflow),
    .res_parity   (res_parity)
  );

  typedef struct {
    logic [1:0]        rid;
    int                nb;
    logic [3:0][127:0] d;
    logic [127:0]      exp_d;
    int                exp_cnt;
  } vec_t;

  vec_t tbl [5];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic exp_par(input logic [127:0] d);
`ifdef WIDEXOR_ARB_PARITY_EN
    return ^d;
`else
    return 1'b0;
`endif
  endfunction

  // Present one beat, wait (bounded) for ready, and let it be accepted.
  // Returns on the falling edge after the accepting rising edge.
  task automatic send_beat(input logic [1:0] rid, input logic [127:0] d, input logic last);
    int n;
    n = 0;
    words[rid]     = d;
    req_last[rid]  = last;
    req_valid[rid] = 1'b1;
    while (req_ready[rid] !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      total++;
      bad++;
      $display("FAIL ready_timeout: rid=%0d got no ready want ready within 50 cycles", rid);
    end else begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic check_result(input string nm, input logic [1:0] id, input logic [127:0] d,
                              input int cnt, input logic ovf);
    int n;
    n = 0;
    while (res_valid !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got no res_valid want res_valid within 50 cycles", nm);
    end else begin
      $display("txn %s id=%0d data=%h count=%0d ovf=%0b par=%0b",
               nm, res_id, res_data, res_count, res_overflow, res_parity);
      chk({nm, "_data"},   res_data,     d);
      chk({nm, "_id"},     res_id,       id);
      chk({nm, "_count"},  res_count,    cnt);
      chk({nm, "_ovf"},    res_overflow, ovf);
      chk({nm, "_parity"}, res_parity,   exp_par(d));
    end
  endtask

  task automatic accept_result();
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic check_reset_outputs(input string nm);
    chk({nm, "_req_ready"},    req_ready,    '0);
    chk({nm, "_res_valid"},    res_valid,    1'b0);
    chk({nm, "_res_data"},     res_data,     '0);
    chk({nm, "_res_id"},       res_id,       '0);
    chk({nm, "_res_count"},    res_count,    '0);
    chk({nm, "_res_overflow"}, res_overflow, 1'b0);
    chk({nm, "_res_parity"},   res_parity,   1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0] rid;
    logic [1:0] exp_id;
    logic [3:0] exp_oh;
    int         n;

    // Directed vectors with hand-computed results.
    tbl[0] = '{rid: 2'd2, nb: 3, d: {128'h0, 128'hFF, 128'hF0, 128'h0F},
               exp_d: 128'h0, exp_cnt: 3};
    tbl[1] = '{rid: 2'd0, nb: 1, d: {128'h0, 128'h0, 128'h0, 128'h1},
               exp_d: 128'h1, exp_cnt: 1};
    tbl[2] = '{rid: 2'd3, nb: 2,
               d: {128'h0, 128'h0,
                   128'h00000000_00000000_00000000_12345678,
                   128'hDEADBEEF_00000000_00000000_00000000},
               exp_d: 128'hDEADBEEF_00000000_00000000_12345678, exp_cnt: 2};
    tbl[3] = '{rid: 2'd1, nb: 4,
               d: {128'h1, 128'h80000000_00000000_00000000_00000000, ~128'h0, ~128'h0},
               exp_d: 128'h80000000_00000000_00000000_00000001, exp_cnt: 4};
    tbl[4] = '{rid: 2'd3, nb: 1, d: {128'h0, 128'h0, 128'h0, ~128'h0},
               exp_d: ~128'h0, exp_cnt: 1};

    rst_n     = 1'b0;
    req_valid = '0;
    req_last  = '0;
    res_ready = 1'b0;
    for (int k = 0; k < N; k++) words[k] = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("reset");

    // Table-driven single-requester transactions.
    for (int i = 0; i < 5; i++) begin
      rid = tbl[i].rid;
      for (int b = 0; b < tbl[i].nb; b++) begin
        send_beat(rid, tbl[i].d[b], (b == tbl[i].nb - 1));
      end
      req_valid[rid] = 1'b0;
      req_last[rid]  = 1'b0;
      check_result($sformatf("vec%0d", i), rid, tbl[i].exp_d, tbl[i].exp_cnt, 1'b0);
      accept_result();
    end

    // Round robin: last grant was 3, so order is 0,1,2,3,0.
    for (int k = 0; k < N; k++) words[k] = 128'(k + 1);
    req_last  = '1;
    req_valid = '1;
    for (int j = 0; j < 5; j++) begin
      exp_id = 2'(j % 4);
      exp_oh = 4'b0001 << exp_id;
      n = 0;
      while (req_ready === '0 && n < 50) begin
        @(negedge clk);
        n++;
      end
      chk($sformatf("rr%0d_grant", j), req_ready, exp_oh);
      @(posedge clk);
      @(negedge clk);
      if (j == 4) req_valid = '0;
      check_result($sformatf("rr%0d", j), exp_id, 128'(exp_id) + 128'h1, 1, 1'b0);
      accept_result();
    end
    req_last = '0;

    // Overflow: 17 beats of 0x3, last only on beat 17.
    for (int b = 0; b < MB; b++) send_beat(2'd1, 128'h3, 1'b0);
    check_result("ovf_cut", 2'd1, 128'h0, 16, 1'b1);
    accept_result();
    send_beat(2'd1, 128'h3, 1'b1);
    req_valid[1] = 1'b0;
    req_last[1]  = 1'b0;
    check_result("ovf_tail", 2'd1, 128'h3, 1, 1'b0);
    accept_result();

    // Result held for 10 cycles while another requester waits.
    send_beat(2'd0, 128'hABC, 1'b1);
    req_valid[0] = 1'b0;
    req_last[0]  = 1'b0;
    words[2]     = 128'h77;
    req_last[2]  = 1'b1;
    req_valid[2] = 1'b1;
    check_result("hold", 2'd0, 128'hABC, 1, 1'b0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk($sformatf("hold%0d_req_ready", c), req_ready, '0);
      chk($sformatf("hold%0d_res_valid", c), res_valid, 1'b1);
      chk($sformatf("hold%0d_res_data", c),  res_data,  128'hABC);
    end
    accept_result();
    send_beat(2'd2, 128'h77, 1'b1);
    req_valid[2] = 1'b0;
    req_last[2]  = 1'b0;
    check_result("after_hold", 2'd2, 128'h77, 1, 1'b0);
    accept_result();

    // Asynchronous reset after beat 2 of a 4-beat transaction.
    send_beat(2'd3, 128'h11, 1'b0);
    send_beat(2'd3, 128'h22, 1'b0);
    chk("pre_rst_ready", req_ready, 4'b1000);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    req_valid = '0;
    req_last  = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_beat(2'd3, 128'h5, 1'b1);
    req_valid[3] = 1'b0;
    req_last[3]  = 1'b0;
    check_result("post_rst", 2'd3, 128'h5, 1, 1'b0);
    accept_result();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
